multiport_register_file: RTL and testbench
==========================================

// Module: multiport_register_file
// PURPOSE
//  Second-generation ARM register file for the pipelined core.
//  Adds parametrised read-port count and two write ports: A for ALU
//  writeback, B for load writeback. Adds write-first bypass, a
//  per-register load scoreboard with a stall output, and field-masked
//  CPSR writes. PC stays in register PC_INDEX and advances under a stall gate.
// PARAMETERS
//  WORD_SIZE   32           data width
//  NUM_REGS    16           architectural registers
//  ADDR_WIDTH  4            clog2(NUM_REGS)
//  NUM_RD      3            read ports (rn, rm, rs)
//  PC_INDEX    15           register holding PC
//  PC_STEP     4            PC increment per advancing cycle
//  CPSR_RESET  32'h0000_00D3 CPSR value on reset (SVC, IRQ/FIQ masked)
// PORTS
//  clk        in   1                    clock, rising edge
//  reset      in   1                    asynchronous, active-high
//  rd_addr    in   NUM_RD*ADDR_WIDTH    read addresses, port k at [k*AW+:AW]
//  rd_data    out  NUM_RD*WORD_SIZE     read data, same packing
//  rd_busy    out  NUM_RD               port k addresses a scoreboarded reg
//  stall      out  1                    OR of rd_busy[k] where rd_used[k]
//  rd_used    in   NUM_RD               port k operand is needed this cycle
//  wa_we      in   1                    write port A enable (ALU)
//  wa_addr    in   ADDR_WIDTH           write port A address
//  wa_data    in   WORD_SIZE            write port A data
//  wb_we      in   1                    write port B enable (load); clears busy
//  wb_addr    in   ADDR_WIDTH           write port B address
//  wb_data    in   WORD_SIZE            write port B data
//  mark_we    in   1                    set busy bit of mark_addr (load issue)
//  mark_addr  in   ADDR_WIDTH           register being loaded
//  pc_we      in   1                    branch: load PC from pc_in
//  pc_in      in   WORD_SIZE            branch target
//  pc_en      in   1                    PC may advance this cycle
//  pc_out     out  WORD_SIZE            current PC (registered)
//  cpsr_we    in   1                    CPSR write enable
//  cpsr_mask  in   4                    field mask {f,s,x,c} = bytes {3,2,1,0}
//  cpsr_in    in   WORD_SIZE            CPSR write data
//  cpsr_out   out  WORD_SIZE            current CPSR
// BEHAVIOUR
//  Reset (async): all regs 0, all busy bits 0, cpsr=CPSR_RESET, pc_out=0.
//  Reads are combinational, write-first bypass: B data if wb hits, then A
//   data if wa hits (A overrides B). Bypass does not apply to PC_INDEX;
//   reads of PC_INDEX return pc_out.
//  rd_busy[k] = busy[addr_k] & ~(wb_we & wb_addr==addr_k); B clears
//   same-cycle. stall is combinational; zero-latency.
//  Register update at posedge, non-PC: A and B same address -> A wins.
//  PC next-value priority: pc_we -> pc_in; else wa_we to PC_INDEX -> wa_data;
//   else wb_we to PC_INDEX -> wb_data; else pc_en & ~stall -> pc+PC_STEP;
//   else hold. Increment wraps modulo 2^WORD_SIZE.
//  Scoreboard: mark_we sets busy; wb_we clears busy. Set and clear on
//   the same reg in one cycle -> set wins. wa_we does not touch busy.
//   mark_we to PC_INDEX is ignored.
//  CPSR: for each i, cpsr_mask[i] & cpsr_we -> byte i <= cpsr_in byte i;
//   unmasked bytes hold.
//  Reset mid-operation clears busy bits; loads in flight are dropped.
//  No $display or other simulation-only side effects in RTL.
// STRUCTURE
//  regfile_pkg: PC_INDEX, PC_STEP, CPSR_RESET, CPSR field-index constants.
//  Sub-module regfile_scoreboard: NUM_REGS busy vector, set/clear logic
//   and per-port rd_busy lookup. The top level holds storage, bypass,
//   PC and CPSR.
// TESTING
//  1 reset; read r0..r15 -> all 0, cpsr_out=0x000000D3, stall=0.
//  2 wa_we r3=0xDEADBEEF and read r3 in the same cycle -> rd_data=0xDEADBEEF;
//    wa,wb both r5 (0x11,0x22) -> r5=0x11.
//  3 mark r7; next cycle read r7 with rd_used=1 -> stall=1 and PC holds.
//    wb r7=0x55 -> same cycle rd_busy=0 and data=0x55; PC resumes +4.
//  4 pc_en=1 for 3 cycles from 0 -> pc_out 4,8,12. pc_we=1 with pc_in=0x100
//    and wa_we r15=0x200 together -> 0x100. pc=0xFFFFFFFC +4 -> 0.
//  5 cpsr_we, mask=4'b1000, cpsr_in=0xF0000000 -> cpsr_out=0xF00000D3.
//  6 mark r2 and wb r2 in the same cycle -> busy stays 1. Assert reset
//    mid-stall -> busy clears and stall drops without waiting for a clock.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the pipelined-core register file: default geometry,
// PC location/step, CPSR reset value and CPSR field byte positions.
package regfile_pkg;

    localparam int RF_WORD_SIZE  = 32;
    localparam int RF_NUM_REGS   = 16;
    localparam int RF_ADDR_WIDTH = 4;
    localparam int RF_NUM_RD     = 3;

    localparam int PC_INDEX = 15;
    localparam int PC_STEP  = 4;

    localparam logic [RF_WORD_SIZE-1:0] CPSR_RESET = 32'h0000_00D3;

    // CPSR fields {f,s,x,c} each own one byte, c in the lowest.
    typedef enum logic [1:0] {
        CPSR_FIELD_C = 2'd0,
        CPSR_FIELD_X = 2'd1,
        CPSR_FIELD_S = 2'd2,
        CPSR_FIELD_F = 2'd3
    } cpsr_field_e;

    localparam int CPSR_NUM_FIELDS = 4;
    localparam int CPSR_FIELD_BITS = 8;

    function automatic int cpsr_field_lsb(input cpsr_field_e field);
        return int'(field) * CPSR_FIELD_BITS;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register load scoreboard: busy bits set at load issue, cleared by load
// writeback, with same-cycle writeback masking on each read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int PC_IDX     = PC_INDEX
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mark_we,
    input  logic [ADDR_WIDTH-1:0]        mark_addr,
    input  logic                         wb_we,
    input  logic [ADDR_WIDTH-1:0]        wb_addr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear first, then set, so a load issued in the same cycle as a writeback
    // to that register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wb_we && (wb_addr == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (mark_we && (mark_addr == ADDR_WIDTH'(i)) && (i != PC_IDX)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [ADDR_WIDTH-1:0] addr;
        assign addr       = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_busy[k] = busy_q[addr] & ~(wb_we & (wb_addr == addr));
    end

endmodule

// File: rtl/multiport_register_file.sv
// Register file with NUM_RD bypassed read ports, ALU and load write ports,
// load scoreboard with stall, gated PC advance and field-masked CPSR.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int                    WORD_SIZE  = RF_WORD_SIZE,
    parameter int                    NUM_REGS   = RF_NUM_REGS,
    parameter int                    ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int                    NUM_RD     = RF_NUM_RD,
    parameter int                    PC_IDX     = PC_INDEX,
    parameter int                    PC_INC     = PC_STEP,
    parameter logic [WORD_SIZE-1:0]  CPSR_INIT  = CPSR_RESET
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*WORD_SIZE-1:0]  rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    output logic                         stall,
    input  logic [NUM_RD-1:0]            rd_used,
    input  logic                         wa_we,
    input  logic [ADDR_WIDTH-1:0]        wa_addr,
    input  logic [WORD_SIZE-1:0]         wa_data,
    input  logic                         wb_we,
    input  logic [ADDR_WIDTH-1:0]        wb_addr,
    input  logic [WORD_SIZE-1:0]         wb_data,
    input  logic                         mark_we,
    input  logic [ADDR_WIDTH-1:0]        mark_addr,
    input  logic                         pc_we,
    input  logic [WORD_SIZE-1:0]         pc_in,
    input  logic                         pc_en,
    output logic [WORD_SIZE-1:0]         pc_out,
    input  logic                         cpsr_we,
    input  logic [CPSR_NUM_FIELDS-1:0]   cpsr_mask,
    input  logic [WORD_SIZE-1:0]         cpsr_in,
    output logic [WORD_SIZE-1:0]         cpsr_out
);

    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_IDX);
    localparam logic [WORD_SIZE-1:0]  PC_ADD  = WORD_SIZE'(PC_INC);

    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic [WORD_SIZE-1:0] pc_next;
    logic [WORD_SIZE-1:0] cpsr_q;
    logic                 wa_pc_hit;
    logic                 wb_pc_hit;

    regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .PC_IDX     (PC_IDX)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .mark_we   (mark_we),
        .mark_addr (mark_addr),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

    assign stall  = |(rd_busy & rd_used);
    assign pc_out = regs[PC_IDX];

    // Read ports: PC reads see the registered PC, other registers see
    // same-cycle writes with port A taking precedence over port B.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_SIZE-1:0]  data;

        assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            if (addr == PC_ADDR) begin
                data = pc_out;
            end else if (wa_we && (wa_addr == addr)) begin
                data = wa_data;
            end else if (wb_we && (wb_addr == addr)) begin
                data = wb_data;
            end else begin
                data = regs[addr];
            end
        end

        assign rd_data[k*WORD_SIZE +: WORD_SIZE] = data;
    end

    assign wa_pc_hit = wa_we && (wa_addr == PC_ADDR);
    assign wb_pc_hit = wb_we && (wb_addr == PC_ADDR);

    always_comb begin
        pc_next = pc_out;
        if (pc_we) begin
            pc_next = pc_in;
        end else if (wa_pc_hit) begin
            pc_next = wa_data;
        end else if (wb_pc_hit) begin
            pc_next = wb_data;
        end else if (pc_en && !stall) begin
            pc_next = pc_out + PC_ADD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == PC_IDX) begin
                    regs[i] <= pc_next;
                end else if (wa_we && (wa_addr == ADDR_WIDTH'(i))) begin
                    regs[i] <= wa_data;
                end else if (wb_we && (wb_addr == ADDR_WIDTH'(i))) begin
                    regs[i] <= wb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpsr_q <= CPSR_INIT;
        end else if (cpsr_we) begin
            for (int f = 0; f < CPSR_NUM_FIELDS; f++) begin
                if (cpsr_mask[f]) begin
                    cpsr_q[f*CPSR_FIELD_BITS +: CPSR_FIELD_BITS] <=
                        cpsr_in[f*CPSR_FIELD_BITS +: CPSR_FIELD_BITS];
                end
            end
        end
    end

    assign cpsr_out = cpsr_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: bypass, write priority,
// scoreboard stall, PC sequencing, CPSR field masks and async reset.
module tb_multiport_register_file;

    logic        clk;
    logic        reset;
    logic [11:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic        stall;
    logic [2:0]  rd_used;
    logic        wa_we;
    logic [3:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mark_we;
    logic [3:0]  mark_addr;
    logic        pc_we;
    logic [31:0] pc_in;
    logic        pc_en;
    logic [31:0] pc_out;
    logic        cpsr_we;
    logic [3:0]  cpsr_mask;
    logic [31:0] cpsr_in;
    logic [31:0] cpsr_out;

    int vectors;
    int miscompares;

    multiport_register_file dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .stall     (stall),
        .rd_used   (rd_used),
        .wa_we     (wa_we),
        .wa_addr   (wa_addr),
        .wa_data   (wa_data),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .mark_we   (mark_we),
        .mark_addr (mark_addr),
        .pc_we     (pc_we),
        .pc_in     (pc_in),
        .pc_en     (pc_en),
        .pc_out    (pc_out),
        .cpsr_we   (cpsr_we),
        .cpsr_mask (cpsr_mask),
        .cpsr_in   (cpsr_in),
        .cpsr_out  (cpsr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int port, input logic [3:0] addr);
        rd_addr[port*4 +: 4] = addr;
    endtask

    function automatic logic [31:0] port_data(input int port);
        return rd_data[port*32 +: 32];
    endfunction

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        rd_addr = '0; rd_used = '0;
        wa_we = 0; wa_addr = '0; wa_data = '0;
        wb_we = 0; wb_addr = '0; wb_data = '0;
        mark_we = 0; mark_addr = '0;
        pc_we = 0; pc_in = '0; pc_en = 0;
        cpsr_we = 0; cpsr_mask = '0; cpsr_in = '0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state
        for (int r = 0; r < 16; r++) begin
            set_rd(0, 4'(r));
            #1;
            chk($sformatf("reset_r%0d", r), port_data(0), 32'h0);
        end
        chk("reset_cpsr", cpsr_out, 32'h0000_00D3);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_pc", pc_out, 32'h0);

        // Write-first bypass and A-over-B priority
        wa_we = 1; wa_addr = 4'd3; wa_data = 32'hDEAD_BEEF;
        set_rd(1, 4'd3);
        #1;
        chk("bypass_a_r3", port_data(1), 32'hDEAD_BEEF);
        step();
        wa_we = 0;
        #1;
        chk("stored_r3", port_data(1), 32'hDEAD_BEEF);
        wa_we = 1; wa_addr = 4'd5; wa_data = 32'h11;
        wb_we = 1; wb_addr = 4'd5; wb_data = 32'h22;
        set_rd(0, 4'd5);
        #1;
        chk("bypass_ab_r5", port_data(0), 32'h11);
        step();
        wa_we = 0; wb_we = 0;
        #1;
        chk("stored_ab_r5", port_data(0), 32'h11);
        wb_we = 1; wb_addr = 4'd6; wb_data = 32'h66;
        set_rd(0, 4'd6);
        #1;
        chk("bypass_b_r6", port_data(0), 32'h66);
        step();
        wb_we = 0;

        // Load scoreboard stall
        mark_we = 1; mark_addr = 4'd7;
        step();
        mark_we = 0;
        set_rd(2, 4'd7); rd_used = 3'b100; pc_en = 1;
        #1;
        chk("busy_r7", {29'b0, rd_busy}, 32'h4);
        chk("stall_r7", {31'b0, stall}, 32'h1);
        step();
        chk("pc_hold_stall", pc_out, 32'h0);
        wb_we = 1; wb_addr = 4'd7; wb_data = 32'h55;
        #1;
        chk("busy_clear_r7", {29'b0, rd_busy}, 32'h0);
        chk("stall_clear_r7", {31'b0, stall}, 32'h0);
        chk("wb_bypass_r7", port_data(2), 32'h55);
        step();
        chk("pc_resume", pc_out, 32'h4);
        wb_we = 0; pc_en = 0;
        #1;
        chk("busy_after_wb_r7", {29'b0, rd_busy}, 32'h0);
        chk("stored_r7", port_data(2), 32'h55);
        rd_used = 3'b000;

        // PC sequencing
        pc_we = 1; pc_in = 32'h0;
        step();
        pc_we = 0; pc_en = 1;
        step();
        chk("pc_4", pc_out, 32'h4);
        step();
        chk("pc_8", pc_out, 32'h8);
        step();
        chk("pc_12", pc_out, 32'hC);
        pc_en = 0;
        pc_we = 1; pc_in = 32'h100;
        wa_we = 1; wa_addr = 4'd15; wa_data = 32'h200;
        set_rd(0, 4'd15);
        #1;
        chk("pc_read_no_bypass", port_data(0), 32'hC);
        step();
        chk("pc_branch_wins", pc_out, 32'h100);
        pc_we = 0;
        wa_data = 32'h300;
        step();
        chk("pc_wa_write", pc_out, 32'h300);
        chk("pc_read_r15", port_data(0), 32'h300);
        wa_we = 0;
        pc_we = 1; pc_in = 32'hFFFF_FFFC;
        step();
        pc_we = 0; pc_en = 1;
        step();
        chk("pc_wrap", pc_out, 32'h0);
        pc_en = 0;

        // CPSR field masks
        cpsr_we = 1; cpsr_mask = 4'b1000; cpsr_in = 32'hF000_0000;
        step();
        chk("cpsr_f", cpsr_out, 32'hF000_00D3);
        cpsr_mask = 4'b0001; cpsr_in = 32'hAAAA_AA1F;
        step();
        chk("cpsr_c", cpsr_out, 32'hF000_001F);
        cpsr_we = 0; cpsr_mask = 4'b1111; cpsr_in = 32'h1234_5678;
        step();
        chk("cpsr_hold", cpsr_out, 32'hF000_001F);

        // Mark to PC ignored; set wins over clear; async reset mid-stall
        mark_we = 1; mark_addr = 4'd15;
        step();
        mark_we = 0;
        set_rd(1, 4'd15); rd_used = 3'b010;
        #1;
        chk("mark_pc_ignored", {31'b0, stall}, 32'h0);
        mark_we = 1; mark_addr = 4'd2;
        wb_we = 1; wb_addr = 4'd2; wb_data = 32'h77;
        step();
        mark_we = 0; wb_we = 0;
        set_rd(0, 4'd2); rd_used = 3'b001; pc_en = 1;
        #1;
        chk("set_wins_busy", {31'b0, rd_busy[0]}, 32'h1);
        chk("set_wins_stall", {31'b0, stall}, 32'h1);
        chk("set_wins_data", port_data(0), 32'h77);
        step();
        chk("pc_hold_r2", pc_out, 32'h0);
        reset = 1;
        #1;
        chk("reset_async_stall", {31'b0, stall}, 32'h0);
        chk("reset_async_busy", {29'b0, rd_busy}, 32'h0);
        chk("reset_async_cpsr", cpsr_out, 32'h0000_00D3);
        chk("reset_async_r2", port_data(0), 32'h0);
        step();
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
